// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state type, default width and sign helpers for seq_divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Helpers work on 33 bits so any legal WIDTH (up to 32) plus a sign bit fits.
    function automatic logic [32:0] twos_neg(input logic [32:0] v);
        return ~v + 33'd1;
    endfunction

    function automatic logic [32:0] twos_abs(input logic [32:0] v);
        return v[32] ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift {r,q} left and trial-subtract d
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // r < d always holds, so the shifted partial remainder and the trial fit in WIDTH+1 bits.
    assign shifted = {r, q[WIDTH-1]};
    assign trial   = shifted - {1'b0, d};
    assign r_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider; SEQ_DIVIDER_SIGNED_EN selects two's-complement operands
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t          state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Magnitudes go through a wider sign-extended value so |most negative| is representable.
    assign dvd_mag = WIDTH'(twos_abs(33'(signed'(dividend))));
    assign dvs_mag = WIDTH'(twos_abs(33'(signed'(divisor))));
    assign q_fix   = neg_q ? WIDTH'(twos_neg(33'(q))) : q;
    assign r_fix   = neg_r ? WIDTH'(twos_neg(33'(r))) : r;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_fix   = q;
    assign r_fix   = r;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        r           <= '0;
                        q           <= dvd_mag;
                        d           <= dvs_mag;
                        count       <= CNT_INIT;
                        div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r       <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to DONE with the raw dividend.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_pass;

    seq_divider #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
        if (b == '0) begin
            q   = '1;
            r   = a;
            z   = 1'b1;
            lat = 1;
        end else begin
            z   = 1'b0;
            lat = W + 2;
`ifdef SEQ_DIVIDER_SIGNED_EN
            begin
                int sa;
                int sb;
                sa = int'(signed'(a));
                sb = int'(signed'(b));
                q  = W'(sa / sb);
                r  = W'(sa % sb);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           elat;
        int           n;
        model(a, b, eq, er, ez, elat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n = 1;
        check("busy_after_start", busy, (elat > 1) ? 1 : 0);
        while (!done && n < W + 12) begin
            tick();
            n++;
        end
        check("latency", n, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        check("busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("result_holds", quotient, eq);
    endtask

    initial begin
        int n;
        int dn;
        int first;
        int last;
        logic [W-1:0] cq;
        logic [W-1:0] cr;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        // directed cases, including the signed corner patterns
        run_op(4'd13, 4'd3);
        run_op(4'd9, 4'd0);
        run_op(4'b1001, 4'd2);
        run_op(4'd7, 4'b1110);
        run_op(4'b1000, 4'b1111);
        run_op(4'd15, 4'd1);
        run_op(4'd0, 4'd5);
        run_op(4'd15, 4'd15);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // start and new operands during an operation must be ignored
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        dividend = 4'd15;
        divisor  = 4'd1;
        n = 1; dn = 0; first = 0; cq = '0; cr = '0;
        while (n < W + 14) begin
            if (done) begin
                dn++;
                if (first == 0) begin
                    first = n;
                    cq = quotient;
                    cr = remainder;
                end
            end
            if (n == 3) start = 1'b0;
            tick();
            n++;
        end
        check("ignore_latency", first, W + 2);
        check("ignore_done_count", dn, 1);
        check("ignore_quotient", cq, 4);
        check("ignore_remainder", cr, 1);

        // reset in the middle of an operation aborts it
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        dn = 0;
        for (int i = 0; i < W + 6; i++) begin
            if (done) dn++;
            tick();
        end
        check("abort_no_done", dn, 0);
        run_op(4'd6, 4'd2);

        // start held high: back-to-back operations
        dividend = 4'd10;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        n = 1; dn = 0; last = 0;
        while (n < 40) begin
            if (done) begin
                dn++;
                check("b2b_quotient", quotient, 3);
                check("b2b_remainder", remainder, 1);
                if (last != 0) check("b2b_period", n - last, W + 3);
                else check("b2b_first", n, W + 2);
                last = n;
            end
            if (n == 20) start = 1'b0;
            tick();
            n++;
        end
        check("b2b_done_count", dn, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
